serial_row_loader: RTL and testbench

- Parametrised serial-to-parallel dataset loader that feeds the SGD core's training memory.
- Deserialises a bit stream of WORD_W-bit words arriving on LANES serial lines, LSB first.
- Each dataset row is (feat+1) words, highest word index first (y value first). A row is assembled and written as one DATA_WIDTH-wide memory word.
- New over the single-lane loader: explicit start/s_valid/abort handshake, multi-lane input, done/busy status, and optional per-word parity.

---
 rtl/serial_row_loader_pkg.sv | 32 +++
 rtl/word_deserializer.sv | 102 ++++++++++
 rtl/serial_row_loader.sv | 179 +++++++++++++++++
 tb/tb_serial_row_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_row_loader_pkg.sv
// ============================================================================
// Package     : loader_pkg
// Description : Shared defaults, FSM state encoding and the bit-counter width
//               helper used by serial_row_loader and word_deserializer.
// Optional    : none here (SERIAL_PARITY_EN is consumed by the modules)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

  localparam int DEF_WORD_W       = 16;
  localparam int DEF_MAX_FEATURES = 15;
  localparam int DEF_DATA_WIDTH   = DEF_WORD_W * (DEF_MAX_FEATURES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that indexes the WORD_W/LANES beats of one word.
  // A single-beat word (LANES == WORD_W) still gets a 1-bit counter.
  function automatic int bit_cnt_width(input int word_w, input int lanes);
    int beats;
    beats = word_w / lanes;
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage : loader_pkg

`default_nettype wire

// File: rtl/word_deserializer.sv
// ============================================================================
// Module      : word_deserializer
// Description : Collects LANES serial bits per enabled cycle, LSB first, into a
//               WORD_W-bit word and flags the cycle in which the word is
//               complete. With SERIAL_PARITY_EN defined, every word is followed
//               by one extra beat whose lane 0 carries even parity; the word is
//               released on that beat together with the parity result.
// Ports       : CLK, RST (async, active low)
//               clear_i      - drop any partial word, restart the beat count
//               en_i         - sample S_i this cycle
//               S_i          - lane k carries bit LANES*n+k of the word
//               word_o       - assembled word (valid while word_ready_o = 1)
//               word_ready_o - combinational completion flag
//               par_err_o    - parity mismatch on the completing beat
// Optional    : SERIAL_PARITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_deserializer
  import loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LANES  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [LANES-1:0]  S_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_o,
  output logic              par_err_o
);

`ifdef SERIAL_PARITY_EN
  localparam int c_PAR_BEATS = 1;
`else
  localparam int c_PAR_BEATS = 0;
`endif
  localparam int c_BEATS = WORD_W / LANES;
  localparam int c_CNT_W = bit_cnt_width(WORD_W, LANES) + c_PAR_BEATS;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1 + c_PAR_BEATS);

  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WORD_W-1:0]  shift_in;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;

  // New lanes enter at the top and move down, so after c_BEATS shifts the
  // first bits received sit at bit 0.
  generate
    if (LANES == WORD_W) begin : g_single_beat
      assign shift_in = S_i;
    end else begin : g_multi_beat
      assign shift_in = {S_i, shreg_q[WORD_W-1:LANES]};
    end
  endgenerate

  always_comb begin
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    word_ready_o = 1'b0;
    par_err_o    = 1'b0;
`ifdef SERIAL_PARITY_EN
    // The parity beat does not shift; the word is already complete in shreg.
    word_o = shreg_q;
    if (en_i) begin
      if (cnt_q == c_LAST) begin
        word_ready_o = 1'b1;
        par_err_o    = ((^shreg_q) != S_i[0]);
      end else begin
        shreg_d = shift_in;
      end
    end
`else
    word_o = shift_in;
    if (en_i) begin
      shreg_d      = shift_in;
      word_ready_o = (cnt_q == c_LAST);
    end
`endif
    if (en_i) begin
      cnt_d = word_ready_o ? '0 : cnt_q + c_CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : word_deserializer

`default_nettype wire

// File: rtl/serial_row_loader.sv
// ============================================================================
// Module      : serial_row_loader
// Description : Serial-to-parallel dataset loader. Rows of (feat+1) words
//               arrive highest word index first; each completed row is written
//               as one DATA_WIDTH-wide memory word at consecutive row addresses
//               until data_points+1 rows have been written.
// Ports       : CLK, RST (async, active low)
//               start, abort      - load request / cancel
//               feat, data_points - row shape and last row index (on start)
//               s_valid, S        - serial stream, LANES bits per valid cycle
//               wr_en, wr_addr, wr_data - row write port (held between strobes)
//               busy, done        - status
//               parity_err        - sticky parity mismatch (0 without parity)
// Optional    : SERIAL_PARITY_EN - per-word even parity beat on lane 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_row_loader
  import loader_pkg::*;
#(
  parameter int WORD_W       = DEF_WORD_W,
  parameter int MAX_FEATURES = DEF_MAX_FEATURES,
  parameter int ADDR_WIDTH   = 12,
  parameter int LANES        = 1,
  parameter int DATA_WIDTH   = WORD_W * (MAX_FEATURES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            feat,
  input  logic [ADDR_WIDTH-1:0] data_points,
  input  logic                  s_valid,
  input  logic [LANES-1:0]      S,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  parity_err
);

  state_t                state_q;
  logic [3:0]            feat_q;
  logic [ADDR_WIDTH-1:0] dp_q;
  logic [3:0]            word_idx_q;
  logic [ADDR_WIDTH-1:0] row_idx_q;
  logic [DATA_WIDTH-1:0] row_buf_q;
  logic [DATA_WIDTH-1:0] row_ins_d;
  logic                  last_wr_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  par_err_q;

  logic                  in_load;
  logic                  des_clear;
  logic                  des_en;
  logic [WORD_W-1:0]     des_word;
  logic                  des_ready;
  logic                  des_par_err;

  assign in_load   = (state_q == LOAD);
  // Abort wins over start; start is only honoured outside LOAD.
  assign des_clear = (start && !in_load) || (abort && in_load);
  assign des_en    = s_valid && in_load && !abort;

  word_deserializer #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_deser (
    .CLK          (CLK),
    .RST          (RST),
    .clear_i      (des_clear),
    .en_i         (des_en),
    .S_i          (S),
    .word_o       (des_word),
    .word_ready_o (des_ready),
    .par_err_o    (des_par_err)
  );

  // Row buffer with the completing word dropped into slot word_idx_q.
  always_comb begin
    row_ins_d = row_buf_q;
    for (int j = 0; j <= MAX_FEATURES; j++) begin
      if (word_idx_q == 4'(j)) begin
        row_ins_d[j*WORD_W +: WORD_W] = des_word;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      dp_q       <= '0;
      word_idx_q <= '0;
      row_idx_q  <= '0;
      row_buf_q  <= '0;
      last_wr_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= LOAD;
            feat_q     <= feat;
            dp_q       <= data_points;
            word_idx_q <= feat;
            row_idx_q  <= '0;
            row_buf_q  <= '0;
            last_wr_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            par_err_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            row_idx_q  <= '0;
            row_buf_q  <= '0;
            word_idx_q <= feat_q;
            last_wr_q  <= 1'b0;
          end else if (last_wr_q) begin
            // Final strobe is on the bus this cycle; report completion next.
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            last_wr_q <= 1'b0;
          end else if (des_ready) begin
            if (des_par_err) begin
              par_err_q <= 1'b1;
            end
            if (word_idx_q == 4'd0) begin
              wr_en_q    <= 1'b1;
              wr_addr_q  <= row_idx_q;
              wr_data_q  <= row_ins_d;
              row_buf_q  <= '0;
              word_idx_q <= feat_q;
              row_idx_q  <= row_idx_q + ADDR_WIDTH'(1);
              if (row_idx_q == dp_q) begin
                last_wr_q <= 1'b1;
              end
            end else begin
              row_buf_q  <= row_ins_d;
              word_idx_q <= word_idx_q - 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_err = par_err_q;

endmodule : serial_row_loader

`default_nettype wire

// File: tb/tb_serial_row_loader.sv
// ============================================================================
// Module      : tb_serial_row_loader
// Description : Self-checking bench for serial_row_loader. One instance with
//               LANES=1 and one with LANES=4 share clock and reset. Expected
//               row writes are queued as rows are driven and compared when the
//               strobe appears.
// Optional    : SERIAL_PARITY_EN (parity beats and parity checks)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_row_loader;

  localparam int AW = 12;
  localparam int DW = 256;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic [15:0]   word;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          start1 = 1'b0, abort1 = 1'b0, sv1 = 1'b0;
  logic [3:0]    feat1 = '0;
  logic [AW-1:0] dp1 = '0;
  logic [0:0]    s1 = '0;
  logic          wr_en1, busy1, done1, perr1;
  logic [AW-1:0] wr_addr1;
  logic [DW-1:0] wr_data1;

  logic          start4 = 1'b0, abort4 = 1'b0, sv4 = 1'b0;
  logic [3:0]    feat4 = '0;
  logic [AW-1:0] dp4 = '0;
  logic [3:0]    s4 = '0;
  logic          wr_en4, busy4, done4, perr4;
  logic [AW-1:0] wr_addr4;
  logic [DW-1:0] wr_data4;

  exp_t q1[$];
  exp_t q4[$];
  int   total = 0;
  int   bad = 0;
  int   gapcnt = 0;

  always #5 clk = ~clk;

  serial_row_loader #(.WORD_W(16), .MAX_FEATURES(15), .ADDR_WIDTH(AW), .LANES(1), .DATA_WIDTH(DW)) u_dut1 (
    .CLK(clk), .RST(rst_n), .start(start1), .abort(abort1), .feat(feat1),
    .data_points(dp1), .s_valid(sv1), .S(s1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .done(done1), .parity_err(perr1)
  );

  serial_row_loader #(.WORD_W(16), .MAX_FEATURES(15), .ADDR_WIDTH(AW), .LANES(4), .DATA_WIDTH(DW)) u_dut4 (
    .CLK(clk), .RST(rst_n), .start(start4), .abort(abort4), .feat(feat4),
    .data_points(dp4), .s_valid(sv4), .S(s4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .wr_data(wr_data4), .busy(busy4), .done(done4), .parity_err(perr4)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] val(input int seed, input int j);
    return 16'((seed * 929 + j * 4951 + 241) ^ (j << 8));
  endfunction

  function automatic logic [DW-1:0] exp_row(input int seed, input int f);
    logic [DW-1:0] d;
    d = '0;
    for (int j = 0; j <= f; j++) d[j*16 +: 16] = val(seed, j);
    return d;
  endfunction

  task automatic send_word1(input logic [15:0] w, input bit gaps, input bit bad_par);
    for (int n = 0; n < 16; n++) begin
      sv1 = 1'b1;
      s1  = w[n];
      tick();
      gapcnt++;
      if (gaps && (gapcnt % 5 == 0)) begin
        sv1 = 1'b0;
        repeat (3) tick();
      end
    end
`ifdef SERIAL_PARITY_EN
    sv1 = 1'b1;
    s1  = (^w) ^ bad_par;
    tick();
`endif
    sv1 = 1'b0;
  endtask

  task automatic send_row1(input int seed, input int addr, input int f, input bit gaps);
    q1.push_back('{AW'(addr), exp_row(seed, f)});
    for (int j = f; j >= 0; j--) send_word1(val(seed, j), gaps, 1'b0);
  endtask

  task automatic send_word4(input logic [15:0] w);
    for (int n = 0; n < 4; n++) begin
      sv4 = 1'b1;
      s4  = w[4*n +: 4];
      tick();
    end
`ifdef SERIAL_PARITY_EN
    sv4 = 1'b1;
    s4  = {3'b000, ^w};
    tick();
`endif
    sv4 = 1'b0;
  endtask

  task automatic start_load1(input logic [3:0] f, input logic [AW-1:0] dp);
    start1 = 1'b1;
    feat1  = f;
    dp1    = dp;
    tick();
    start1 = 1'b0;
  endtask

  // Scoreboard: every strobe must match the oldest queued row.
  always @(negedge clk) begin : mon
    exp_t e;
    if (wr_en1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe1_unexpected actual addr=%0d required no strobe", wr_addr1);
      end else begin
        e = q1.pop_front();
        chk("strobe1_addr", DW'(wr_addr1), DW'(e.addr));
        chk("strobe1_data", wr_data1, e.data);
      end
    end
    if (wr_en4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe4_unexpected actual addr=%0d required no strobe", wr_addr4);
      end else begin
        e = q4.pop_front();
        chk("strobe4_addr", DW'(wr_addr4), DW'(e.addr));
        chk("strobe4_data", wr_data4, e.data);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t tbl[3];
    logic [DW-1:0] w0;
    tbl[0] = '{16'hA5C3, 12'd0, {240'b0, 16'hA5C3}};
    tbl[1] = '{16'h1234, 12'd1, {240'b0, 16'h1234}};
    tbl[2] = '{16'hFFFF, 12'd2, {240'b0, 16'hFFFF}};

    // Reset state
    repeat (3) tick();
    chk("rst_wr_en", DW'(wr_en1), '0);
    chk("rst_wr_addr", DW'(wr_addr1), '0);
    chk("rst_wr_data", wr_data1, '0);
    chk("rst_busy_done", DW'({busy1, done1, perr1, busy4, done4, perr4}), '0);
    rst_n = 1'b1;
    tick();

    // Nominal load: feat=11, 7 rows, continuous stream
    start_load1(4'd11, 12'd6);
    chk("nom_busy", DW'(busy1), DW'(1));
    for (int r = 0; r < 7; r++) send_row1(r, r, 11, 1'b0);
    @(negedge clk);
    chk("nom_last_strobe", DW'({wr_en1, done1, busy1}), DW'(3'b101));
    @(negedge clk);
    chk("nom_done", DW'({wr_en1, done1, busy1}), DW'(3'b010));
    chk("nom_first_word", DW'(wr_data1[191:176]), DW'(val(6, 11)));
    chk("nom_upper_zero", DW'(wr_data1[255:192]), '0);
    chk("nom_queue_empty", DW'(q1.size()), '0);
`ifndef SERIAL_PARITY_EN
    chk("nom_parity_tied0", DW'(perr1), '0);
`endif

    // Same stream with s_valid gaps; restart from DONE
    gapcnt = 0;
    start_load1(4'd11, 12'd6);
    chk("gap_done_cleared", DW'({busy1, done1}), DW'(2'b10));
    for (int r = 0; r < 7; r++) send_row1(r, r, 11, 1'b1);
    repeat (4) @(negedge clk);
    chk("gap_done", DW'({done1, busy1}), DW'(2'b10));
    chk("gap_queue_empty", DW'(q1.size()), '0);
    repeat (5) tick();
    chk("hold_addr", DW'(wr_addr1), DW'(6));
    chk("hold_data", wr_data1, exp_row(6, 11));

    // Multi-lane table: LANES=4, feat=0, three rows
    start4 = 1'b1; feat4 = 4'd0; dp4 = 12'd2;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      q4.push_back('{tbl[i].addr, tbl[i].data});
      send_word4(tbl[i].word);
      @(negedge clk);
      chk("lane4_strobe", DW'(wr_en4), DW'(1));
      chk("lane4_word", DW'(wr_data4[15:0]), DW'(tbl[i].word));
    end
    repeat (2) @(negedge clk);
    chk("lane4_done", DW'({done4, busy4}), DW'(2'b10));
    chk("lane4_queue_empty", DW'(q4.size()), '0);

    // Abort after 20 bits of row 3
    start_load1(4'd11, 12'd6);
    for (int r = 0; r < 3; r++) send_row1(r + 20, r, 11, 1'b0);
    w0 = exp_row(23, 11);
    for (int n = 0; n < 20; n++) begin
      sv1 = 1'b1;
      s1  = (n < 16) ? w0[176 + n] : w0[160 + n - 16];
      tick();
    end
    abort1 = 1'b1;
    start1 = 1'b1;
    tick();
    abort1 = 1'b0;
    start1 = 1'b0;
    chk("abort_idle", DW'({busy1, done1}), '0);
    for (int n = 0; n < 200; n++) begin
      s1 = 1'(n);
      tick();
    end
    sv1 = 1'b0;
    chk("abort_no_strobe", DW'(q1.size()), '0);
    chk("abort_still_idle", DW'({busy1, done1}), '0);

    // Restart after abort: feat=0, data_points=0 -> one row at address 0
    start_load1(4'd0, 12'd0);
    send_row1(9, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reload_done", DW'({done1, busy1}), DW'(2'b10));
    chk("reload_queue_empty", DW'(q1.size()), '0);

`ifdef SERIAL_PARITY_EN
    // Bad parity on word 0x0001: row written, flag sticky until next start
    start_load1(4'd0, 12'd1);
    q1.push_back('{12'd0, {240'b0, 16'h0001}});
    send_word1(16'h0001, 1'b0, 1'b1);
    @(negedge clk);
    chk("par_err_set", DW'(perr1), DW'(1));
    q1.push_back('{12'd1, {240'b0, 16'h0003}});
    send_word1(16'h0003, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("par_err_sticky", DW'({perr1, done1}), DW'(2'b11));
    start_load1(4'd0, 12'd0);
    chk("par_err_cleared", DW'(perr1), '0);
    send_row1(5, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("par_good_clean", DW'({perr1, done1}), DW'(2'b01));
`endif

    // Asynchronous reset mid-row
    start_load1(4'd11, 12'd6);
    send_row1(30, 0, 11, 1'b0);
    w0 = exp_row(31, 11);
    for (int n = 0; n < 10; n++) begin
      sv1 = 1'b1;
      s1  = w0[176 + n];
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_data", wr_data1, '0);
    chk("arst_status", DW'({wr_en1, busy1, done1, perr1}), '0);
    chk("arst_wr_addr", DW'(wr_addr1), '0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    sv1 = 1'b0;
    chk("arst_idle", DW'({busy1, done1}), '0);
    chk("final_queues", DW'(q1.size() + q4.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_row_loader

`default_nettype wire
